// File: rtl/bus_interconnect_if.sv
// Single-master, N-slave memory-mapped bus bundle: master request/response plus shared slave strobes.
// No storage or latency here; the interconnect module drives the response side.
// Backpressure: the master holds read/write until response, and slaves complete via slave_response.
interface bus_interconnect_if #(
    parameter int NUM_SLAVES = 4
);
    logic                       read;
    logic                       write;
    logic [31:0]                address;
    logic [31:0]                write_data;
    logic [31:0]                read_data;
    logic                       response;
    logic                       error;
    logic                       busy;
    logic [15:0]                error_count;
    logic [NUM_SLAVES-1:0]      slave_read;
    logic [NUM_SLAVES-1:0]      slave_write;
    logic [31:0]                slave_address;
    logic [31:0]                slave_write_data;
    logic [32*NUM_SLAVES-1:0]   slave_read_data;
    logic [NUM_SLAVES-1:0]      slave_response;

    // The environment view: the core drives requests and the peripherals drive completions.
    modport master (
        output read, write, address, write_data, slave_read_data, slave_response,
        input  read_data, response, error, busy, error_count,
        input  slave_read, slave_write, slave_address, slave_write_data
    );

    // The interconnect view.
    modport slave (
        input  read, write, address, write_data, slave_read_data, slave_response,
        output read_data, response, error, busy, error_count,
        output slave_read, slave_write, slave_address, slave_write_data
    );
endinterface

// File: rtl/bus_interconnect.sv
// Registered-decode single-master interconnect with an error response for unmapped, illegal or timed-out accesses.
// Latency: response 2 cycles after the request for an immediate slave, 1 cycle for errors, TIMEOUT_CYCLES+1 cycles on timeout.
// Backpressure: one transaction in flight; master inputs are ignored until the response pulse.
module bus_interconnect #(
    parameter int          NUM_SLAVES     = 4,
    parameter int          SEL_LSB        = 28,
    parameter int          SEL_WIDTH      = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    bus_interconnect_if.slave bus
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t                 state;
    logic [TW-1:0]          timer;
    logic [SEL_WIDTH-1:0]   idx_q;
    logic                   op_read;

    logic [SEL_WIDTH-1:0]   req_idx;
    logic                   req_mapped;
    logic [NUM_SLAVES-1:0]  req_onehot;
    logic                   sel_resp;
    logic [31:0]            sel_data;

    assign req_idx    = bus.address[SEL_LSB +: SEL_WIDTH];
    assign req_mapped = {1'b0, req_idx} < (SEL_WIDTH+1)'(NUM_SLAVES);

    // Request strobe is decoded from the live address; completion is muxed from the latched index.
    always_comb begin
        req_onehot = '0;
        sel_resp   = 1'b0;
        sel_data   = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (req_idx == SEL_WIDTH'(k))
                req_onehot[k] = 1'b1;
            if (idx_q == SEL_WIDTH'(k)) begin
                sel_resp = bus.slave_response[k];
                sel_data = bus.slave_read_data[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            timer                <= '0;
            idx_q                <= '0;
            op_read              <= 1'b0;
            bus.read_data        <= '0;
            bus.response         <= 1'b0;
            bus.error            <= 1'b0;
            bus.busy             <= 1'b0;
            bus.error_count      <= '0;
            bus.slave_read       <= '0;
            bus.slave_write      <= '0;
            bus.slave_address    <= '0;
            bus.slave_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.response <= 1'b0;
                    bus.error    <= 1'b0;
                    bus.busy     <= 1'b0;
                    if (bus.read ^ bus.write) begin
                        bus.slave_address    <= bus.address;
                        bus.slave_write_data <= bus.write_data;
                        op_read              <= bus.read;
                        idx_q                <= req_idx;
                        bus.busy             <= 1'b1;
                        if (req_mapped) begin
                            bus.slave_read  <= bus.read  ? req_onehot : '0;
                            bus.slave_write <= bus.write ? req_onehot : '0;
                            timer           <= '0;
                            state           <= ACCESS;
                        end else begin
                            bus.error     <= 1'b1;
                            bus.read_data <= ERROR_DATA;
                            state         <= RESPOND;
                        end
                    end else if (bus.read && bus.write) begin
                        bus.error     <= 1'b1;
                        bus.read_data <= ERROR_DATA;
                        bus.busy      <= 1'b1;
                        state         <= RESPOND;
                    end
                end
                ACCESS: begin
                    timer <= timer + 1'b1;
                    // A slave completing on the last allowed cycle still beats the timeout.
                    if (sel_resp) begin
                        bus.read_data   <= op_read ? sel_data : '0;
                        bus.slave_read  <= '0;
                        bus.slave_write <= '0;
                        bus.error       <= 1'b0;
                        state           <= RESPOND;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        bus.slave_read  <= '0;
                        bus.slave_write <= '0;
                        bus.error       <= 1'b1;
                        bus.read_data   <= ERROR_DATA;
                        state           <= RESPOND;
                    end
                end
                RESPOND: begin
                    bus.response <= 1'b1;
                    bus.busy     <= 1'b1;
                    if (bus.error && (bus.error_count != 16'hFFFF))
                        bus.error_count <= bus.error_count + 16'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_interconnect.sv
// Bench for bus_interconnect: directed scenarios plus randomized transactions against a latency/result model.
// Slaves are modelled per index with a programmable response delay measured from the first strobe cycle.
module tb_bus_interconnect;
    localparam int          NS = 4;
    localparam int          TO = 8;
    localparam logic [31:0] ED = 32'hDEADBEEF;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_interconnect_if #(.NUM_SLAVES(NS)) bus();

    bus_interconnect #(
        .NUM_SLAVES(NS), .SEL_LSB(28), .SEL_WIDTH(4),
        .TIMEOUT_CYCLES(TO), .ERROR_DATA(ED)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat[NS];
    logic [31:0] sdata[NS];
    int          model_errs = 0;

    // One transaction: the model predicts latency, strobe length and result from the decode rules.
    task automatic do_txn(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit noise);
        int          idx;
        bit          strobed;
        int          exp_lat, exp_strb;
        logic        exp_err;
        logic [31:0] exp_data;
        int          got, strb_cnt, wrong, addr_bad, dir_bad, busy_bad;
        logic        got_err;
        logic [31:0] got_data;

        idx     = int'(addr[31:28]);
        strobed = (rd ^ wr) && (idx < NS);
        if (!strobed) begin
            exp_lat = 1; exp_strb = 0; exp_err = 1'b1; exp_data = ED;
        end else if (lat[idx] < TO) begin
            exp_lat = lat[idx] + 2; exp_strb = lat[idx] + 1; exp_err = 1'b0; exp_data = sdata[idx];
        end else begin
            exp_lat = TO + 1; exp_strb = TO; exp_err = 1'b1; exp_data = ED;
        end
        if (exp_err && model_errs < 65535) model_errs++;

        @(negedge clk);
        bus.slave_read_data = {sdata[3], sdata[2], sdata[1], sdata[0]};
        bus.slave_response  = '0;
        bus.read = rd; bus.write = wr; bus.address = addr; bus.write_data = wdata;
        got = -1; strb_cnt = 0; wrong = 0; addr_bad = 0; dir_bad = 0; busy_bad = 0;
        got_err = 1'b0; got_data = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.response === 1'b1) begin
                got = c; got_err = bus.error; got_data = bus.read_data;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            for (int k = 0; k < NS; k++) begin
                if (bus.slave_read[k] === 1'b1 || bus.slave_write[k] === 1'b1) begin
                    if (strobed && k == idx) strb_cnt++;
                    else wrong++;
                    if (bus.slave_read[k] !== rd || bus.slave_write[k] !== wr) dir_bad++;
                    if (bus.slave_address !== addr || bus.slave_write_data !== wdata) addr_bad++;
                end
            end
            if (noise) begin
                bus.address    = $urandom;
                bus.write_data = $urandom;
            end
            for (int k = 0; k < NS; k++) begin
                if (strobed && k == idx)
                    bus.slave_response[k] = (bus.slave_read[k] | bus.slave_write[k]) && (strb_cnt - 1 >= lat[k]);
                else
                    bus.slave_response[k] = noise ? 1'($urandom) : 1'b0;
            end
        end
        bus.read = 1'b0; bus.write = 1'b0; bus.slave_response = '0;

        n_checks++; if (got !== exp_lat) begin n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, got, exp_lat); end
        n_checks++; if (got_err !== exp_err) begin n_fail++;
            $display("FAIL %s error: got %b expected %b", name, got_err, exp_err); end
        if (exp_err || rd) begin
            n_checks++; if (got_data !== exp_data) begin n_fail++;
                $display("FAIL %s read_data: got %h expected %h", name, got_data, exp_data); end
        end
        n_checks++; if (strb_cnt !== exp_strb || wrong !== 0 || dir_bad !== 0) begin n_fail++;
            $display("FAIL %s strobe: cycles %0d (expected %0d) stray %0d dir_bad %0d", name, strb_cnt, exp_strb, wrong, dir_bad); end
        n_checks++; if (addr_bad !== 0) begin n_fail++;
            $display("FAIL %s latched addr/data: %0d bad cycles, expected 0", name, addr_bad); end
        n_checks++; if (busy_bad !== 0) begin n_fail++;
            $display("FAIL %s busy: low in %0d in-flight cycles, expected 0", name, busy_bad); end
        n_checks++; if (bus.error_count !== 16'(model_errs)) begin n_fail++;
            $display("FAIL %s error_count: got %0d expected %0d", name, bus.error_count, model_errs); end
        @(negedge clk);
        n_checks++; if (bus.response !== 1'b0 || bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL %s idle after: response %b busy %b expected 0 0", name, bus.response, bus.busy); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.write_data = '0;
        bus.slave_read_data = '0; bus.slave_response = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.read_data !== 32'h0) begin n_fail++;
            $display("FAIL reset read_data: got %h expected 0", bus.read_data); end
        n_checks++; if ({bus.response, bus.error, bus.busy} !== 3'b000) begin n_fail++;
            $display("FAIL reset flags: got %b expected 000", {bus.response, bus.error, bus.busy}); end
        n_checks++; if (bus.error_count !== 16'h0) begin n_fail++;
            $display("FAIL reset error_count: got %0d expected 0", bus.error_count); end
        n_checks++; if ({bus.slave_read, bus.slave_write} !== 8'h0) begin n_fail++;
            $display("FAIL reset strobes: got %b expected 0", {bus.slave_read, bus.slave_write}); end
        n_checks++; if ({bus.slave_address, bus.slave_write_data} !== 64'h0) begin n_fail++;
            $display("FAIL reset slave bus: got %h expected 0", {bus.slave_address, bus.slave_write_data}); end
        reset = 1'b0;
        model_errs = 0;
    endtask

    task automatic test_read_basic();
        for (int k = 0; k < NS; k++) begin lat[k] = 99; sdata[k] = 32'h1111_0000 + k; end
        lat[1] = 1; sdata[1] = 32'h0000_00A5;
        do_txn("read_slave1", 1'b1, 1'b0, 32'h1000_0004, 32'h0, 1'b0);
        lat[2] = 0; sdata[2] = 32'hCAFE_0002;
        do_txn("read_comb", 1'b1, 1'b0, 32'h2000_0010, 32'h0, 1'b0);
    endtask

    task automatic test_write();
        lat[3] = 2;
        do_txn("write_slave3", 1'b0, 1'b1, 32'h3000_0000, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_unmapped();
        do_txn("unmapped", 1'b1, 1'b0, 32'h5000_0000, 32'h0, 1'b0);
        do_txn("unmapped_top", 1'b0, 1'b1, 32'hF000_0000, 32'h55AA_55AA, 1'b0);
    endtask

    task automatic test_timeout();
        lat[0] = 99;
        do_txn("timeout", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
        lat[2] = TO - 1; sdata[2] = 32'h0BAD_F00D;
        do_txn("last_cycle_resp", 1'b1, 1'b0, 32'h2000_0008, 32'h0, 1'b1);
    endtask

    task automatic test_illegal();
        do_txn("illegal", 1'b1, 1'b1, 32'h1000_0000, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            logic [1:0]  op;
            logic [31:0] addr;
            op   = 2'($urandom_range(1, 3));
            addr = {4'($urandom_range(0, 7)), 28'($urandom)};
            for (int k = 0; k < NS; k++) begin
                lat[k]   = $urandom_range(0, 9);
                sdata[k] = $urandom;
            end
            do_txn("random", op[1], op[0], addr, $urandom, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        int late_resp;
        lat[0] = 99;
        @(negedge clk);
        bus.read = 1'b1; bus.write = 1'b0; bus.address = 32'h0000_0010; bus.write_data = '0;
        bus.slave_response = '0;
        for (int c = 0; c < 3; c++) @(negedge clk);
        reset = 1'b1; bus.read = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.slave_read, bus.slave_write} !== 8'h0 || bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_mid state: strobes %b busy %b expected 0", {bus.slave_read, bus.slave_write}, bus.busy); end
        n_checks++; if (bus.error_count !== 16'h0) begin n_fail++;
            $display("FAIL reset_mid error_count: got %0d expected 0", bus.error_count); end
        reset = 1'b0;
        model_errs = 0;
        late_resp = 0;
        bus.slave_response = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.response === 1'b1 || bus.busy === 1'b1) late_resp++;
        end
        bus.slave_response = '0;
        n_checks++; if (late_resp !== 0) begin n_fail++;
            $display("FAIL reset_mid late response: %0d active cycles, expected 0", late_resp); end
        lat[1] = 3; sdata[1] = 32'h7777_1234;
        do_txn("after_reset", 1'b1, 1'b0, 32'h1000_0020, 32'h0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < NS; k++) begin lat[k] = 99; sdata[k] = '0; end
        test_reset();
        test_read_basic();
        test_write();
        test_unmapped();
        test_timeout();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
